// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath-level types: the memory request controller state and latched request.
package data_path_muxs_pkg;
   import cpu_types_pkg::*;

   typedef logic [1:0] mem_req_state_t;

   localparam mem_req_state_t MEM_IDLE = 2'd0;
   localparam mem_req_state_t MEM_BUSY = 2'd1;
   localparam mem_req_state_t MEM_DONE = 2'd2;

   typedef struct packed {
      logic  ren;
      logic  wen;
      word_t addr;
      word_t data;
   } mem_req_t;

endpackage

// File: rtl/mem_req_ctrl.sv
// MEM-stage request controller: holds a dcache request until dhit, captures load data
// and drives the MEM/WB enable while stalling the front of the pipe.
module mem_req_ctrl
   import cpu_types_pkg::*;
   import data_path_muxs_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  dREN_EX_MEM,
   input  logic  dWEN_EX_MEM,
   input  word_t addr_EX_MEM,
   input  word_t store_EX_MEM,
   input  logic  flush_MEM,
   input  logic  dhit,
   input  word_t dcache_load,
   output logic  dmemREN,
   output logic  dmemWEN,
   output word_t dmemaddr,
   output word_t dmemstore,
   output word_t dmemload,
   output logic  enable_MEM_WB,
   output logic  mem_stall,
   output logic  timeout_o
);

   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

   mem_req_state_t state_q, state_d;
   mem_req_t       req_q, req_d;
   word_t          load_q, load_d;
   logic           drop_q, drop_d;
   logic [15:0]    cnt_q, cnt_d;
   logic           tmo_q, tmo_d;

   logic mem_op;
   logic in_idle, in_busy, in_done;

   assign mem_op  = (dREN_EX_MEM | dWEN_EX_MEM) & ~flush_MEM;
   assign in_idle = (state_q == MEM_IDLE);
   assign in_busy = (state_q == MEM_BUSY);
   assign in_done = (state_q == MEM_DONE);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      load_d  = load_q;
      drop_d  = drop_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      case (state_q)
         MEM_IDLE: begin
            if (mem_op) begin
               req_d.ren  = dREN_EX_MEM;
               req_d.wen  = dWEN_EX_MEM & ~dREN_EX_MEM;
               req_d.addr = addr_EX_MEM;
               req_d.data = store_EX_MEM;
               // counter holds BUSY cycles so far, including the current one
               cnt_d      = 16'd1;
               state_d    = MEM_BUSY;
            end
         end
         MEM_BUSY: begin
            if (cnt_q == TIMEOUT_W) tmo_d = 1'b1;
            if (cnt_q != 16'hFFFF)  cnt_d = cnt_q + 16'd1;
            if (flush_MEM)          drop_d = 1'b1;
            if (dhit) begin
               if (req_q.ren && !drop_q && !flush_MEM) load_d = dcache_load;
               req_d.ren = 1'b0;
               req_d.wen = 1'b0;
               state_d   = MEM_DONE;
            end
         end
         MEM_DONE: begin
            drop_d  = 1'b0;
            state_d = MEM_IDLE;
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= MEM_IDLE;
         req_q   <= '0;
         load_q  <= '0;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         load_q  <= load_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign dmemREN   = req_q.ren;
   assign dmemWEN   = req_q.wen;
   assign dmemaddr  = req_q.addr;
   assign dmemstore = req_q.data;
   assign dmemload  = load_q;

   // a flush seen in DONE kills the writeback just like one recorded during BUSY
   assign mem_stall     = (in_idle & mem_op) | in_busy;
   assign enable_MEM_WB = (in_idle & ~mem_op) | (in_done & ~drop_q & ~flush_MEM);
   assign timeout_o     = tmo_q | (in_busy & (cnt_q == TIMEOUT_W));

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Randomized self-checking bench for mem_req_ctrl against a transaction-level timing model.
module tb_mem_req_ctrl;
   import cpu_types_pkg::*;

   localparam int unsigned TMO = 4;

   logic  CLK = 1'b0;
   logic  RST;
   logic  dREN, dWEN, flush, dhit;
   word_t addr, store, dload;
   logic  dmemREN, dmemWEN, enable_MEM_WB, mem_stall, timeout_o;
   word_t dmemaddr, dmemstore, dmemload;

   int n_checks = 0;
   int n_errors = 0;
   word_t exp_load;
   bit    exp_tmo;

   mem_req_ctrl #(.TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .dREN_EX_MEM(dREN), .dWEN_EX_MEM(dWEN),
      .addr_EX_MEM(addr), .store_EX_MEM(store),
      .flush_MEM(flush), .dhit(dhit), .dcache_load(dload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload(dmemload),
      .enable_MEM_WB(enable_MEM_WB), .mem_stall(mem_stall), .timeout_o(timeout_o)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic sample;
      @(negedge CLK);
   endtask

   task automatic idle_inputs;
      dREN  = 1'b0;
      dWEN  = 1'b0;
      flush = 1'b0;
      dhit  = 1'b0;
      addr  = $urandom;
      store = $urandom;
      dload = $urandom;
   endtask

   // non-memory (or flushed memory) instruction: passes straight through
   task automatic pass_op(input bit flushed);
      dREN  = flushed ? 1'($urandom) : 1'b0;
      dWEN  = flushed ? ~dREN        : 1'b0;
      flush = flushed;
      dhit  = 1'($urandom);
      addr  = $urandom;
      store = $urandom;
      sample;
      chk("pass_stall", mem_stall, 0);
      chk("pass_en", enable_MEM_WB, 1);
      chk("pass_ren", dmemREN, 0);
      chk("pass_wen", dmemWEN, 0);
      chk("pass_load", dmemload, exp_load);
      chk("pass_tmo", timeout_o, exp_tmo);
      tick;
      idle_inputs;
   endtask

   // memory op: issue cycle, k BUSY cycles (dhit on the k-th), one DONE cycle
   task automatic mem_txn(input bit ren, input bit wen, input word_t a, input word_t d,
                          input word_t ld, input int k, input int flush_at, input bit flush_done);
      bit rd, wr, dropped;
      rd = ren;
      wr = wen & ~ren;
      dropped = (flush_at != 0);
      dREN = ren; dWEN = wen; addr = a; store = d; flush = 1'b0; dhit = 1'b0;
      sample;
      chk("issue_stall", mem_stall, 1);
      chk("issue_en", enable_MEM_WB, 0);
      chk("issue_ren", dmemREN, 0);
      tick;
      for (int n = 1; n <= k; n++) begin
         dREN  = 1'($urandom);
         dWEN  = 1'($urandom);
         addr  = $urandom;
         store = $urandom;
         flush = (n == flush_at);
         dhit  = (n == k);
         dload = (n == k) ? ld : word_t'($urandom);
         if (n >= int'(TMO)) exp_tmo = 1'b1;
         sample;
         chk("busy_ren", dmemREN, rd);
         chk("busy_wen", dmemWEN, wr);
         chk("busy_addr", dmemaddr, a);
         if (wr) chk("busy_store", dmemstore, d);
         chk("busy_stall", mem_stall, 1);
         chk("busy_en", enable_MEM_WB, 0);
         chk("busy_tmo", timeout_o, exp_tmo);
         tick;
      end
      dREN  = 1'($urandom);
      dWEN  = 1'($urandom);
      flush = flush_done;
      dhit  = 1'($urandom);
      dload = $urandom;
      if (rd && !dropped) exp_load = ld;
      sample;
      chk("done_en", enable_MEM_WB, !(dropped || flush_done));
      chk("done_stall", mem_stall, 0);
      chk("done_ren", dmemREN, 0);
      chk("done_wen", dmemWEN, 0);
      chk("done_load", dmemload, exp_load);
      chk("done_tmo", timeout_o, exp_tmo);
      tick;
      idle_inputs;
   endtask

   task automatic check_reset_values(input string tag);
      sample;
      chk({tag, "_ren"}, dmemREN, 0);
      chk({tag, "_wen"}, dmemWEN, 0);
      chk({tag, "_addr"}, dmemaddr, 0);
      chk({tag, "_store"}, dmemstore, 0);
      chk({tag, "_load"}, dmemload, 0);
      chk({tag, "_stall"}, mem_stall, 0);
      chk({tag, "_en"}, enable_MEM_WB, 1);
      chk({tag, "_tmo"}, timeout_o, 0);
   endtask

   task automatic reset_mid_busy;
      dREN = 1'b1; dWEN = 1'b0; addr = 32'h0000_0100; flush = 1'b0; dhit = 1'b0;
      tick;
      dREN = 1'($urandom);
      addr = $urandom;
      tick;
      RST = 1'b1;
      sample;
      chk("rstb_ren", dmemREN, 1);
      tick;
      RST = 1'b0;
      idle_inputs;
      exp_load = '0;
      exp_tmo  = 1'b0;
      check_reset_values("rst_mid");
      tick;
   endtask

   task automatic random_txns(input int count);
      for (int i = 0; i < count; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            pass_op(1'($urandom));
         end else begin
            bit r, w;
            r = 1'($urandom);
            w = r ? 1'($urandom) : 1'b1;
            mem_txn(r, w, $urandom, $urandom, $urandom, $urandom_range(1, 6),
                    ($urandom_range(0, 4) == 0) ? 1 : 0, ($urandom_range(0, 5) == 0));
         end
      end
   endtask

   initial begin
      RST = 1'b1;
      idle_inputs;
      exp_load = '0;
      exp_tmo  = 1'b0;
      tick;
      tick;
      RST = 1'b0;
      check_reset_values("reset");
      tick;

      for (int i = 0; i < 3; i++) pass_op(1'b0);
      mem_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 3, 0, 1'b0);
      mem_txn(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'h5555_0000, 1, 0, 1'b0);
      mem_txn(1'b1, 1'b0, 32'h0000_00C0, 32'h0, 32'hAAAA_5555, 3, 2, 1'b0);
      mem_txn(1'b1, 1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 32'h0BAD_F00D, 2, 0, 1'b0);
      pass_op(1'b1);
      reset_mid_busy();

      mem_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_0001, 7, 0, 1'b0);
      pass_op(1'b0);

      random_txns(40);
      reset_mid_busy();
      random_txns(25);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
